// File: rtl/icmp_echo_responder.sv
// icmp_echo_responder: buffers one ICMP echo request and returns it as an echo reply
module icmp_echo_responder #(
  parameter int          P_DEPTH   = 32,
  parameter logic [15:0] P_ID_INIT = 16'h0100,
  parameter int          P_CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [63:0]        s_axis_ip_data,
  input  logic [55:0]        s_axis_ip_user,
  input  logic [7:0]         s_axis_ip_keep,
  input  logic               s_axis_ip_last,
  input  logic               s_axis_ip_valid,
  output logic [63:0]        m_axis_ip_data,
  output logic [55:0]        m_axis_ip_user,
  output logic [7:0]         m_axis_ip_keep,
  output logic               m_axis_ip_last,
  output logic               m_axis_ip_valid,
  input  logic               m_axis_ip_ready,
  input  logic               i_reply_en,
  output logic [P_CNT_W-1:0] o_reply_cnt,
  output logic [P_CNT_W-1:0] o_drop_cnt
);
  localparam int AW = $clog2(P_DEPTH);
  localparam logic [16:0] MAX_LEN = 17'(P_DEPTH * 8);
  localparam logic [1:0] S_IDLE = 2'd0, S_RECV = 2'd1, S_DROP = 2'd2, S_SEND = 2'd3;
  logic [1:0] st_q, st_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, lidx_q, lidx_d, wa;
  logic [7:0] lkeep_q, lkeep_d, ok_q, ok_d;
  logic [15:0] len_q, len_d, id_q, id_d, cfix;
  logic [63:0] hdr_q, hdr_d, od_q, od_d, pf_q, w0;
  logic ol_q, ol_d, ov_q, ov_d, mid_q, mid_d, we, echo, acc, xfer;
  logic [P_CNT_W-1:0] rc_q, rc_d, dc_q, dc_d;
  logic [16:0] sum;
  logic [63:0] mem [P_DEPTH];
  logic unused_ok;
  assign unused_ok = ^s_axis_ip_user[15:0];
  assign echo = s_axis_ip_user[36:29] == 8'd1 && s_axis_ip_user[39:37] == 3'd0 &&
                s_axis_ip_user[28:16] == 13'd0 && s_axis_ip_data[63:56] == 8'd8 &&
                s_axis_ip_data[55:48] == 8'd0;
  assign acc = echo && i_reply_en && ({1'b0, s_axis_ip_user[55:40]} <= MAX_LEN);
  // Changing type 8 to 0 adds 0x0800 to the one's-complement checksum field.
  assign sum = {1'b0, s_axis_ip_data[47:32]} + 17'h00800;
  assign cfix = sum[15:0] + {15'd0, sum[16]};
  assign w0 = {16'h0000, cfix, s_axis_ip_data[31:0]};
  assign xfer = ov_q && m_axis_ip_ready;
  assign m_axis_ip_data = od_q;
  assign m_axis_ip_keep = ok_q;
  assign m_axis_ip_last = ol_q;
  assign m_axis_ip_valid = ov_q;
  assign m_axis_ip_user = ov_q ? {len_q, 3'b000, 8'd1, 13'd0, id_q} : 56'd0;
  assign o_reply_cnt = rc_q;
  assign o_drop_cnt = dc_q;
  // Receive/drop/send sequencing; mid_d tracks message framing so SEND can drop overlapping RX.
  always_comb begin
    st_d = st_q; wr_d = wr_q; lidx_d = lidx_q; lkeep_d = lkeep_q; len_d = len_q; id_d = id_q;
    hdr_d = hdr_q; od_d = od_q; ok_d = ok_q; ol_d = ol_q; ov_d = ov_q; rc_d = rc_q; dc_d = dc_q;
    rd_d = AW'(1); we = 1'b0; wa = wr_q;
    mid_d = s_axis_ip_valid ? !s_axis_ip_last : mid_q;
    case (st_q)
      S_IDLE: if (s_axis_ip_valid) begin
        if (acc) begin
          we = 1'b1; wa = '0; hdr_d = w0; len_d = s_axis_ip_user[55:40]; wr_d = AW'(1);
          if (s_axis_ip_last) begin
            st_d = S_SEND; od_d = w0; ok_d = s_axis_ip_keep; ol_d = 1'b1; ov_d = 1'b1; lidx_d = '0;
          end else st_d = S_RECV;
        end else begin
          dc_d = dc_q + P_CNT_W'(echo);
          st_d = s_axis_ip_last ? S_IDLE : S_DROP;
        end
      end
      S_RECV: if (s_axis_ip_valid) begin
        we = 1'b1; wr_d = wr_q + AW'(1);
        if (s_axis_ip_last) begin
          st_d = S_SEND; od_d = hdr_q; ok_d = 8'hFF; ol_d = 1'b0; ov_d = 1'b1;
          lidx_d = wr_q; lkeep_d = s_axis_ip_keep;
        end else if (wr_q == AW'(P_DEPTH - 1)) begin
          st_d = S_DROP; dc_d = dc_q + P_CNT_W'(1);
        end
      end
      S_DROP: st_d = (s_axis_ip_valid && s_axis_ip_last) ? S_IDLE : S_DROP;
      default: begin
        dc_d = dc_q + P_CNT_W'(s_axis_ip_valid && !mid_q && echo);
        rd_d = rd_q;
        if (xfer && ol_q) begin
          ov_d = 1'b0; rc_d = rc_q + P_CNT_W'(1); id_d = id_q + 16'd1;
          st_d = mid_d ? S_DROP : S_IDLE;
        end else if (xfer) begin
          od_d = pf_q; ol_d = rd_q == lidx_q; ok_d = (rd_q == lidx_q) ? lkeep_q : 8'hFF;
          rd_d = rd_q + AW'(1);
        end
      end
    endcase
  end
  // Packet buffer with a registered prefetch of the next word, forwarding a same-cycle write.
  always_ff @(posedge i_clk) begin
    if (we) mem[wa] <= s_axis_ip_data;
    pf_q <= (we && wa == rd_d) ? s_axis_ip_data : mem[rd_d];
  end
  // Control and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q <= S_IDLE; wr_q <= '0; rd_q <= AW'(1); lidx_q <= '0; lkeep_q <= '0; len_q <= '0;
      id_q <= P_ID_INIT; hdr_q <= '0; od_q <= '0; ok_q <= '0; ol_q <= 1'b0; ov_q <= 1'b0;
      mid_q <= 1'b0; rc_q <= '0; dc_q <= '0;
    end else begin
      st_q <= st_d; wr_q <= wr_d; rd_q <= rd_d; lidx_q <= lidx_d; lkeep_q <= lkeep_d; len_q <= len_d;
      id_q <= id_d; hdr_q <= hdr_d; od_q <= od_d; ok_q <= ok_d; ol_q <= ol_d; ov_q <= ov_d;
      mid_q <= mid_d; rc_q <= rc_d; dc_q <= dc_d;
    end
  end
endmodule

// File: tb/tb_icmp_echo_responder.sv
// tb_icmp_echo_responder: directed and randomized checks of echo replies against a byte-level model
module tb_icmp_echo_responder;
  logic clk, rst;
  logic [63:0] s_data, m_data;
  logic [55:0] s_user, m_user;
  logic [7:0] s_keep, m_keep;
  logic s_last, s_valid, m_last, m_valid, m_ready, en;
  logic [15:0] rcnt, dcnt;
  icmp_echo_responder dut (
    .i_clk(clk), .i_rst(rst),
    .s_axis_ip_data(s_data), .s_axis_ip_user(s_user), .s_axis_ip_keep(s_keep),
    .s_axis_ip_last(s_last), .s_axis_ip_valid(s_valid),
    .m_axis_ip_data(m_data), .m_axis_ip_user(m_user), .m_axis_ip_keep(m_keep),
    .m_axis_ip_last(m_last), .m_axis_ip_valid(m_valid), .m_axis_ip_ready(m_ready),
    .i_reply_en(en), .o_reply_cnt(rcnt), .o_drop_cnt(dcnt)
  );
  int errors = 0, checks = 0;
  logic [7:0] req[$], exp_b[$];
  logic [63:0] got_data[$];
  logic [55:0] got_user[$];
  logic [7:0] got_keep[$];
  logic got_last[$];
  logic end_seen = 1'b0, rnd = 1'b0, pstall = 1'b0;
  logic [63:0] pd;
  logic [55:0] pu, last_user;
  logic [7:0] pk, last_keep;
  logic pl;
  logic [15:0] model_id, exp_reply, exp_drop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rnd) m_ready = 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge clk);
    if (rst) pstall = 1'b0;
    else begin
      if (pstall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", m_data, pd);
        chk("stall_ctl", {m_user, m_keep, m_last}, {pu, pk, pl});
      end
      if (m_valid && m_ready) begin
        got_data.push_back(m_data); got_user.push_back(m_user);
        got_keep.push_back(m_keep); got_last.push_back(m_last);
        if (m_last) end_seen = 1'b1;
      end
      pstall = m_valid && !m_ready;
      pd = m_data; pu = m_user; pk = m_keep; pl = m_last;
    end
  end

  function automatic logic [15:0] ref_csum(input logic [15:0] c);
    int t;
    t = int'(c) + 'h800;
    if (t > 'hFFFF) t = t - 'hFFFF;
    return t[15:0];
  endfunction

  task automatic build(input int n, input logic [15:0] c, input logic [15:0] id,
                       input logic [15:0] seq, input logic [7:0] t0);
    req = {};
    req.push_back(t0); req.push_back(8'h00); req.push_back(c[15:8]); req.push_back(c[7:0]);
    req.push_back(id[15:8]); req.push_back(id[7:0]); req.push_back(seq[15:8]); req.push_back(seq[7:0]);
    while (req.size() < n) req.push_back(8'($urandom));
  endtask

  task automatic expect_now();
    logic [15:0] c;
    exp_b = req;
    c = ref_csum({req[2], req[3]});
    exp_b[0] = 8'h00; exp_b[1] = 8'h00; exp_b[2] = c[15:8]; exp_b[3] = c[7:0];
  endtask

  task automatic drive_msg();
    int n, nb, rem;
    n = req.size();
    nb = (n + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      logic [63:0] d;
      d = '0;
      for (int b = 0; b < 8; b++) if (8 * k + b < n) d[63-8*b -: 8] = req[8*k+b];
      rem = n - 8 * k;
      s_data = d;
      s_user = {16'(n), 3'b000, 8'd1, 13'd0, 16'h0000};
      s_keep = (k == nb - 1) ? 8'(8'hFF << (8 - rem)) : 8'hFF;
      s_last = (k == nb - 1);
      s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic clear_got();
    got_data = {}; got_user = {}; got_keep = {}; got_last = {}; end_seen = 1'b0;
  endtask

  task automatic check_reply(input string tag, input logic [15:0] csum_c);
    int n, nb;
    logic [63:0] e;
    for (int i = 0; i < 400 && !end_seen; i++) @(posedge clk);
    #1;
    chk({tag, "_done"}, 64'(end_seen), 64'd1);
    n = exp_b.size();
    nb = (n + 7) / 8;
    chk({tag, "_beats"}, 64'(got_data.size()), 64'(nb));
    if (got_data.size() > 0) chk({tag, "_csum"}, 64'(got_data[0][47:32]), 64'(csum_c));
    for (int k = 0; k < nb && k < got_data.size(); k++) begin
      e = '0;
      for (int b = 0; b < 8; b++) if (8 * k + b < n) e[63-8*b -: 8] = exp_b[8*k+b];
      chk($sformatf("%s_data%0d", tag, k), got_data[k], e);
      chk($sformatf("%s_keep%0d", tag, k), 64'(got_keep[k]),
          64'((k == nb - 1) ? 8'(8'hFF << (8 - (n - 8 * k))) : 8'hFF));
      chk($sformatf("%s_last%0d", tag, k), 64'(got_last[k]), 64'(k == nb - 1));
      chk($sformatf("%s_user%0d", tag, k), 64'(got_user[k]),
          64'({16'(n), 3'b000, 8'd1, 13'd0, model_id}));
    end
    if (got_data.size() > 0) begin
      last_keep = got_keep[got_keep.size() - 1];
      last_user = got_user[0];
    end
    clear_got();
    model_id = model_id + 16'd1;
    exp_reply = exp_reply + 16'd1;
    chk({tag, "_rcnt"}, 64'(rcnt), 64'(exp_reply));
    chk({tag, "_dcnt"}, 64'(dcnt), 64'(exp_drop));
  endtask

  task automatic no_output(input string tag);
    repeat (20) @(posedge clk);
    #1;
    chk({tag, "_none"}, 64'(got_data.size()), 64'd0);
    chk({tag, "_dcnt"}, 64'(dcnt), 64'(exp_drop));
    clear_got();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_got();
    model_id = 16'h0100; exp_reply = 16'd0; exp_drop = 16'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_user = '0; s_keep = '0;
    m_ready = 1'b1; en = 1'b1;
    model_id = 16'h0100; exp_reply = 16'd0; exp_drop = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_ctl", {m_user, m_keep, m_last}, 64'd0);
    chk("rst_cnts", {rcnt, dcnt}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    build(64, 16'h1234, 16'h0001, 16'h0007, 8'h08); expect_now(); drive_msg();
    chk("t1_latency", 64'(m_valid), 64'd1);
    check_reply("t1", 16'h1A34);
    chk("t1_id", 64'(last_user[15:0]), 64'h0100);
    chk("t1_rcnt1", 64'(rcnt), 64'd1);
    build(16, 16'hF7FF, 16'h0002, 16'h0001, 8'h08); expect_now(); drive_msg();
    check_reply("t2", 16'hFFFF);
    build(16, 16'hF800, 16'h0003, 16'h0002, 8'h08); expect_now(); drive_msg();
    check_reply("t3", 16'h0001);
    build(13, 16'h4321, 16'h0004, 16'h0003, 8'h08); expect_now(); drive_msg();
    check_reply("t4", ref_csum(16'h4321));
    chk("t4_lastkeep", 64'(last_keep), 64'hF8);
    build(32 * 8 + 8, 16'h1111, 16'h0005, 16'h0004, 8'h08); drive_msg();
    exp_drop = exp_drop + 16'd1;
    no_output("t5_oversize");
    en = 1'b0;
    build(24, 16'h2222, 16'h0006, 16'h0005, 8'h08); drive_msg();
    en = 1'b1;
    exp_drop = exp_drop + 16'd1;
    no_output("t6_disabled");
    build(24, 16'h3333, 16'h0007, 16'h0006, 8'h00); drive_msg();
    no_output("t7_nonecho");
    rnd = 1'b1;
    build(40, 16'($urandom), 16'($urandom), 16'($urandom), 8'h08); expect_now(); drive_msg();
    check_reply("t8", ref_csum({req[2], req[3]}));
    rnd = 1'b0; m_ready = 1'b1;
    do_reset();
    m_ready = 1'b0;
    build(32, 16'h5555, 16'h0010, 16'h0001, 8'h08); expect_now(); drive_msg();
    build(24, 16'h6666, 16'h0011, 16'h0002, 8'h08); drive_msg();
    exp_drop = exp_drop + 16'd1;
    repeat (3) @(posedge clk);
    #1;
    m_ready = 1'b1;
    check_reply("t9a", 16'h5D55);
    chk("t9_dcnt1", 64'(dcnt), 64'd1);
    no_output("t9_second");
    build(16, 16'h7777, 16'h0012, 16'h0003, 8'h08); expect_now(); drive_msg();
    check_reply("t9c", 16'h7F77);
    chk("t9_id", 64'(last_user[15:0]), 64'h0101);
    m_ready = 1'b0;
    build(64, 16'h8888, 16'h0020, 16'h0001, 8'h08); drive_msg();
    chk("t10_sending", 64'(m_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t10_async_valid", 64'(m_valid), 64'd0);
    chk("t10_cnts", {rcnt, dcnt}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_got();
    model_id = 16'h0100; exp_reply = 16'd0; exp_drop = 16'd0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    build(16, 16'h9999, 16'h0021, 16'h0002, 8'h08); expect_now(); drive_msg();
    check_reply("t10", ref_csum(16'h9999));
    chk("t10_id", 64'(last_user[15:0]), 64'h0100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
